// File: rtl/video_timing_rx.sv
// video_timing_rx: measures incoming RGB video timing, detects sync polarity, checksums frames and reports lock
module video_timing_rx #(
  parameter int CNT_W       = 12,
  parameter int LOCK_FRAMES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             vid_hs,
  input  logic             vid_vs,
  input  logic             vid_de,
  input  logic [23:0]      vid_rgb,
  output logic             hs_pol,
  output logic             vs_pol,
  output logic             pol_valid,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] h_active,
  output logic [CNT_W-1:0] v_total,
  output logic [CNT_W-1:0] v_active,
  output logic [31:0]      frame_sum,
  output logic             frame_done,
  output logic             locked,
  output logic             err
);
  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [3:0] LOCK_M1 = 4'(LOCK_FRAMES - 1);
  typedef enum logic [1:0] {SEARCH, MEASURE, CHECK, LOCKED} state_t;
  typedef struct packed {
    logic             s1_hs, s1_vs, s1_de;
    logic [23:0]      s1_rgb;
    logic             s2_hs, s2_vs, s2_de;
    logic             hs_pol, vs_pol, pol_valid;
    logic [CNT_W-1:0] hc, dc, vc, ac, ref_len, ref_dc;
    logic             rl_ok, rd_ok, bad, hs_seen, fe_any, fe_real;
    logic [CNT_W-1:0] h_total, h_active, v_total, v_active;
    logic [31:0]      sum, frame_sum;
    logic             frame_done;
  } dp_t;
  dp_t r, n;
  state_t state, state_n;
  logic [3:0] match_cnt, match_n;
  logic lock_n, err_n, prev_ok, prev_ok_n;
  logic hs_e, vs_e, de_r, close, has_de, meas_same, good;
  logic [CNT_W-1:0] vc_b, ac_b;
  logic [31:0] sum_b;
  logic bad_b, rl_ok_b, rd_ok_b, sat, mis;
  assign hs_e = r.pol_valid & (r.s1_hs ~^ r.hs_pol) & (r.s2_hs ^ r.hs_pol);
  assign vs_e = r.pol_valid & (r.s1_vs ~^ r.vs_pol) & (r.s2_vs ^ r.vs_pol);
  assign de_r = r.s1_de & ~r.s2_de;
  assign close = hs_e & r.hs_seen;
  assign has_de = r.dc != '0;
  assign meas_same = {r.ref_len, r.ref_dc, r.vc, r.ac} == {r.h_total, r.h_active, r.v_total, r.v_active};
  assign good = ~r.bad & meas_same & prev_ok;
  assign hs_pol = r.hs_pol;
  assign vs_pol = r.vs_pol;
  assign pol_valid = r.pol_valid;
  assign h_total = r.h_total;
  assign h_active = r.h_active;
  assign v_total = r.v_total;
  assign v_active = r.v_active;
  assign frame_sum = r.frame_sum;
  assign frame_done = r.frame_done;
  // datapath next state: input pipeline, polarity, line/frame counters, frame latch
  always_comb begin
    n = r;
    n.s1_hs = vid_hs;
    n.s1_vs = vid_vs;
    n.s1_de = vid_de;
    n.s1_rgb = vid_rgb;
    n.s2_hs = r.s1_hs;
    n.s2_vs = r.s1_vs;
    n.s2_de = r.s1_de;
    n.frame_done = r.fe_real;
    n.fe_any = vs_e & (state != SEARCH);
    n.fe_real = vs_e & (state == CHECK || state == LOCKED);
    n.hs_pol = de_r ? ~r.s1_hs : r.hs_pol;
    n.vs_pol = de_r ? ~r.s1_vs : r.vs_pol;
    n.pol_valid = r.pol_valid | de_r;
    vc_b = r.fe_any ? '0 : r.vc;
    ac_b = r.fe_any ? '0 : r.ac;
    sum_b = r.fe_any ? '0 : r.sum;
    bad_b = r.fe_any ? 1'b0 : r.bad;
    rl_ok_b = r.fe_any ? 1'b0 : r.rl_ok;
    rd_ok_b = r.fe_any ? 1'b0 : r.rd_ok;
    sat = (~hs_e & (r.hc == MAX)) | (~hs_e & r.s1_de & (r.dc == MAX)) |
          (hs_e & (vc_b == MAX)) | (close & has_de & (ac_b == MAX));
    mis = (close & rl_ok_b & (r.hc != r.ref_len)) | (close & has_de & rd_ok_b & (r.dc != r.ref_dc)) |
          (de_r & ((r.hs_pol == r.s1_hs) | (r.vs_pol == r.s1_vs)));
    if (r.pol_valid) begin
      n.hc = hs_e ? ONE : (r.hc == MAX ? MAX : r.hc + ONE);
      n.dc = hs_e ? CNT_W'(r.s1_de) : (r.s1_de && r.dc != MAX ? r.dc + ONE : r.dc);
      n.vc = hs_e && vc_b != MAX ? vc_b + ONE : vc_b;
      n.ac = close && has_de && ac_b != MAX ? ac_b + ONE : ac_b;
      n.sum = r.s1_de ? sum_b + 32'(r.s1_rgb) : sum_b;
      n.bad = bad_b | sat | mis;
      n.ref_len = close && !rl_ok_b ? r.hc : r.ref_len;
      n.rl_ok = rl_ok_b | close;
      n.ref_dc = close && has_de && !rd_ok_b ? r.dc : r.ref_dc;
      n.rd_ok = rd_ok_b | (close & has_de);
      n.hs_seen = r.hs_seen | hs_e;
    end
    if (r.fe_real) begin
      n.h_total = r.ref_len;
      n.h_active = r.ref_dc;
      n.v_total = r.vc;
      n.v_active = r.ac;
      n.frame_sum = r.sum;
    end
  end
  // datapath register with async reset and sync clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r <= '0;
    else r <= clr ? '0 : n;
  end
  // lock FSM next state: frame comparison and lock/err decisions at each frame end
  always_comb begin
    state_n = state;
    match_n = match_cnt;
    lock_n = locked;
    err_n = 1'b0;
    prev_ok_n = r.fe_real ? ~r.bad : prev_ok;
    case (state)
      SEARCH: if (r.pol_valid) state_n = MEASURE;
      MEASURE: if (vs_e) begin
        state_n = CHECK;
        match_n = '0;
      end
      CHECK: if (r.fe_real) begin
        match_n = good ? match_cnt + 4'd1 : '0;
        if (good && match_cnt + 4'd1 >= LOCK_M1) begin
          state_n = LOCKED;
          lock_n = 1'b1;
        end
      end
      LOCKED: if (r.fe_real && !good) begin
        state_n = CHECK;
        match_n = '0;
        lock_n = 1'b0;
        err_n = 1'b1;
      end
      default: state_n = SEARCH;
    endcase
  end
  // lock FSM register with async reset and sync clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEARCH;
      match_cnt <= '0;
      locked <= 1'b0;
      err <= 1'b0;
      prev_ok <= 1'b0;
    end else begin
      state <= clr ? SEARCH : state_n;
      match_cnt <= clr ? '0 : match_n;
      locked <= clr ? 1'b0 : lock_n;
      err <= clr ? 1'b0 : err_n;
      prev_ok <= clr ? 1'b0 : prev_ok_n;
    end
  end
endmodule

// File: tb/tb_video_timing_rx.sv
// tb_video_timing_rx: directed checks of timing measurement, polarity, lock, reset and clear behaviour
module tb_video_timing_rx;
  logic clk = 1'b0, rst_n = 1'b1, clr = 1'b0;
  logic vid_hs = 1'b1, vid_vs = 1'b1, vid_de = 1'b0;
  logic [23:0] vid_rgb = '0;
  logic hs_pol, vs_pol, pol_valid, frame_done, locked, err;
  logic [11:0] h_total, h_active, v_total, v_active;
  logic [31:0] frame_sum;
  int n_chk = 0, n_fail = 0, fd_cnt = 0, efd = 0, pix = 0;
  logic [11:0] s_ht, s_ha, s_vt, s_va;
  logic [31:0] s_sum;
  logic s_lock, s_err;
  logic act = 1'b0, ramp = 1'b0;

  video_timing_rx #(.CNT_W(12), .LOCK_FRAMES(2)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_de(vid_de), .vid_rgb(vid_rgb),
    .hs_pol(hs_pol), .vs_pol(vs_pol), .pol_valid(pol_valid),
    .h_total(h_total), .h_active(h_active), .v_total(v_total), .v_active(v_active),
    .frame_sum(frame_sum), .frame_done(frame_done), .locked(locked), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done) begin
    fd_cnt++;
    s_ht = h_total;
    s_ha = h_active;
    s_vt = v_total;
    s_va = v_active;
    s_sum = frame_sum;
    s_lock = locked;
    s_err = err;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int y0, input int y1, input int bad_y);
    for (int y = y0; y <= y1; y++)
      for (int x = 0; x < 20; x++) begin
        @(negedge clk);
        if (y == 0 && x == 0) pix = 0;
        vid_hs = (x < 2) ? act : ~act;
        vid_vs = (y < 2) ? act : ~act;
        vid_de = (y >= 2 && y <= 7 && x >= 4 && x < (y == bad_y ? 15 : 16));
        vid_rgb = ramp ? 24'(pix) : 24'h010203;
        if (vid_de) pix++;
      end
  endtask

  task automatic frame(input string tag, input int bad_y, input int new_done);
    send(0, 9, bad_y);
    efd += new_done;
    chk({tag, "_done_cnt"}, fd_cnt, efd);
  endtask

  task automatic chk_meas(input string tag, input logic [31:0] sum);
    chk({tag, "_h_total"}, s_ht, 20);
    chk({tag, "_h_active"}, s_ha, 12);
    chk({tag, "_v_total"}, s_vt, 10);
    chk({tag, "_v_active"}, s_va, 6);
    chk({tag, "_sum"}, s_sum, sum);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_h_total"}, h_total, 0);
    chk({tag, "_frame_sum"}, frame_sum, 0);
    chk({tag, "_pol_valid"}, pol_valid, 0);
    chk({tag, "_locked"}, locked, 0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    chk("reset_done", frame_done, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    frame("lo_f0", -1, 0);
    frame("lo_f1", -1, 0);
    chk("lo_pol_valid", pol_valid, 1);
    chk("lo_hs_pol", hs_pol, 0);
    chk("lo_vs_pol", vs_pol, 0);
    frame("lo_f2", -1, 1);
    chk_meas("lo_f1", 32'h004890D8);
    chk("lo_f1_locked", s_lock, 0);
    frame("lo_f3", -1, 1);
    chk_meas("lo_f2", 32'h004890D8);
    chk("lo_f2_locked", s_lock, 1);
    chk("lo_f2_err", s_err, 0);
    frame("bad_f4", 3, 1);
    chk("lo_f3_locked", s_lock, 1);
    frame("lo_f5", -1, 1);
    chk("bad_err", s_err, 1);
    chk("bad_locked", s_lock, 0);
    frame("lo_f6", -1, 1);
    chk("relock1_locked", s_lock, 0);
    frame("lo_f7", -1, 1);
    chk("relock2_locked", s_lock, 1);
    send(0, 4, -1);
    efd++;
    chk("pre_rst_done_cnt", fd_cnt, efd);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    send(5, 9, -1);
    chk("partial_done_cnt", fd_cnt, efd);
    frame("rst_a", -1, 0);
    frame("rst_b", -1, 1);
    chk_meas("rst_a", 32'h004890D8);
    chk("rst_a_locked", s_lock, 0);
    frame("rst_c", -1, 1);
    chk("rst_b_locked", s_lock, 1);
    frame("sat_d", -1, 1);
    chk("rst_c_locked", s_lock, 1);
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      vid_hs = ~act;
      vid_vs = ~act;
      vid_de = i[0];
      vid_rgb = 24'h010203;
    end
    frame("sat_e", -1, 1);
    chk("sat_err", s_err, 1);
    chk("sat_locked", s_lock, 0);
    @(negedge clk);
    rst_n = 1'b0;
    act = 1'b1;
    vid_hs = 1'b0;
    vid_vs = 1'b0;
    vid_de = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    frame("hi_f0", -1, 0);
    frame("hi_f1", -1, 0);
    chk("hi_hs_pol", hs_pol, 1);
    chk("hi_vs_pol", vs_pol, 1);
    frame("hi_f2", -1, 1);
    chk_meas("hi_f1", 32'h004890D8);
    chk("hi_f1_locked", s_lock, 0);
    frame("hi_f3", -1, 1);
    chk("hi_f2_locked", s_lock, 1);
    ramp = 1'b1;
    frame("ramp_f4", -1, 1);
    frame("ramp_f5", -1, 1);
    chk_meas("ramp", 32'd2556);
    chk("ramp_locked", s_lock, 1);
    @(negedge clk);
    clr = 1'b1;
    #1 chk("clr_sync_hold", frame_sum, 32'd2556);
    @(negedge clk);
    clr = 1'b0;
    chk_zero("clr");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
